fd_meas: RTL and testbench

Clock-divider output monitor. It samples a slow periodic input (typically a divided clock) on the system clock and measures two things in system-clock cycles: the period (rising edge to rising edge) and the high time. Each completed period is reported with a one-cycle valid strobe. Lock and timeout status flags are also provided. Used on-board to close the loop on the frequency-divider blocks.

---
 rtl/fd_meas_pkg.sv | 17 +
 rtl/fd_meas_sync_edge.sv | 51 +++++
 rtl/fd_meas.sv | 135 +++++++++++++
 tb/tb_fd_meas.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_meas_pkg.sv
// Shared types for the frequency-divider measurement monitor.
package fd_meas_pkg;

    typedef enum logic [1:0] {
        FD_IDLE = 2'd0,
        FD_ARM  = 2'd1,
        FD_MEAS = 2'd2
    } fd_state_e;

    localparam int FD_SYNC_MAX = 3;

    // A fresh measurement is "stable" when both figures repeat the last report.
    function automatic logic fd_same(input logic per_eq, input logic high_eq);
        return per_eq & high_eq;
    endfunction

endpackage

// File: rtl/fd_meas_sync_edge.sv
// Optional synchronizer chain on the measured input followed by a rising-edge detector.
module fd_sync_edge
    import fd_meas_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s_s;
    logic s_dly_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s_s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift chain; the last stage is the synchronized sample.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    sync_q <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // One-cycle history of the synchronized sample for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s_dly_q <= 1'b0;
        end else begin
            s_dly_q <= s_s;
        end
    end

    assign q    = s_s;
    assign rise = s_s & ~s_dly_q;

endmodule

// File: rtl/fd_meas.sv
// Period / high-time monitor for a slow periodic input sampled on clk,
// with lock and sticky timeout status.
module fd_meas
    import fd_meas_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic s_s;
    logic rise_s;

    fd_state_e        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] hcnt_q,    hcnt_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic             valid_q,   valid_d;
    logic             locked_q,  locked_d;
    logic             timeout_q, timeout_d;

    fd_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .nrst (nrst),
        .d    (sig_in),
        .q    (s_s),
        .rise (rise_s)
    );

    // State, counters and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= FD_IDLE;
            cnt_q     <= CNT_ZERO;
            hcnt_q    <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: en low wins over everything, a rise wins over timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!en) begin
            state_d   = FD_IDLE;
            cnt_d     = CNT_ZERO;
            hcnt_d    = CNT_ZERO;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                FD_IDLE: begin
                    state_d = FD_ARM;
                end
                FD_ARM: begin
                    // The first edge only opens the measurement window.
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = FD_MEAS;
                    end else begin
                        state_d = FD_ARM;
                    end
                end
                FD_MEAS: begin
                    if (rise_s) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        locked_d  = fd_same(cnt_q == period_q, hcnt_q == high_q);
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                        hcnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Saturated without an edge: give up and re-arm.
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        cnt_d     = CNT_ZERO;
                        hcnt_d    = CNT_ZERO;
                        state_d   = FD_ARM;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s_s};
                    end
                end
                default: begin
                    state_d = FD_IDLE;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_fd_meas.sv
// Bench for fd_meas: three parameterisations driven by the same stimulus,
// each checked every cycle against a timestamp-based model of the input edges.
module tb_fd_meas;

    logic clk    = 1'b0;
    logic nrst   = 1'b0;
    logic en     = 1'b0;
    logic sig_in = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] p0, h0, p2, h2;
    logic [3:0] p4, h4;
    logic       v0, l0, t0, v2, l2, t2, v4, l4, t4;

    fd_meas #(.CNT_W(8), .SYNC_STAGES(0)) u0 (
        .clk(clk), .nrst(nrst), .en(en), .sig_in(sig_in),
        .period(p0), .high_time(h0), .meas_valid(v0), .locked(l0), .timeout(t0));
    fd_meas #(.CNT_W(8), .SYNC_STAGES(2)) u2 (
        .clk(clk), .nrst(nrst), .en(en), .sig_in(sig_in),
        .period(p2), .high_time(h2), .meas_valid(v2), .locked(l2), .timeout(t2));
    fd_meas #(.CNT_W(4), .SYNC_STAGES(0)) u4 (
        .clk(clk), .nrst(nrst), .en(en), .sig_in(sig_in),
        .period(p4), .high_time(h4), .meas_valid(v4), .locked(l4), .timeout(t4));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 60) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each posedge stores the sampled input; a synchronized sample at edge k is
    // the input of edge k-SYNC_STAGES (zero if that predates the last reset).
    bit samp [0:32767];
    int cyc      = 0;
    int rst_mark = 0;
    int ss_a [3] = '{0, 2, 0};
    int mx_a [3] = '{255, 255, 15};

    bit idle  [3] = '{1'b1, 1'b1, 1'b1};
    bit armed [3] = '{1'b0, 1'b0, 1'b0};
    int r_cyc [3] = '{0, 0, 0};   // cycle of the edge opening the current window
    int hacc  [3] = '{0, 0, 0};   // high samples since that edge
    int e_per [3] = '{0, 0, 0};
    int e_hi  [3] = '{0, 0, 0};
    bit e_val [3] = '{1'b0, 1'b0, 1'b0};
    bit e_lck [3] = '{1'b0, 1'b0, 1'b0};
    bit e_to  [3] = '{1'b0, 1'b0, 1'b0};

    function automatic bit sv(input int j, input int ss);
        int idx;
        idx = j - ss;
        return (idx > rst_mark) ? samp[idx] : 1'b0;
    endfunction

    task automatic step(input int i);
        bit s, rise;
        int p;
        s    = sv(cyc, ss_a[i]);
        rise = s & ~sv(cyc - 1, ss_a[i]);
        p    = cyc - r_cyc[i];
        e_val[i] = 1'b0;
        if (!en) begin
            idle[i] = 1'b1; armed[i] = 1'b0; e_lck[i] = 1'b0; e_to[i] = 1'b0;
        end else if (idle[i]) begin
            idle[i] = 1'b0; armed[i] = 1'b0;
        end else if (!armed[i]) begin
            if (rise) begin armed[i] = 1'b1; r_cyc[i] = cyc; hacc[i] = 1; end
        end else if (rise) begin
            e_lck[i] = (p == e_per[i]) && (hacc[i] == e_hi[i]);
            e_per[i] = p; e_hi[i] = hacc[i]; e_val[i] = 1'b1; e_to[i] = 1'b0;
            r_cyc[i] = cyc; hacc[i] = 1;
        end else if (p == mx_a[i]) begin
            e_to[i] = 1'b1; e_lck[i] = 1'b0; armed[i] = 1'b0;
        end else begin
            hacc[i] += int'(s);
        end
    endtask

    // Model update on every clock edge; async reset returns it to power-on state.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rst_mark = cyc;
            for (int i = 0; i < 3; i++) begin
                idle[i] = 1'b1; armed[i] = 1'b0; e_per[i] = 0; e_hi[i] = 0;
                e_val[i] = 1'b0; e_lck[i] = 1'b0; e_to[i] = 1'b0;
            end
        end else begin
            if (cyc < 32767) cyc++;
            samp[cyc] = sig_in;
            for (int i = 0; i < 3; i++) step(i);
        end
    end

    task automatic chk5(input int i, input int p, input int h, input bit v, input bit l, input bit t);
        chk($sformatf("u%0d.period", i),     p,      e_per[i]);
        chk($sformatf("u%0d.high_time", i),  h,      e_hi[i]);
        chk($sformatf("u%0d.meas_valid", i), int'(v), int'(e_val[i]));
        chk($sformatf("u%0d.locked", i),     int'(l), int'(e_lck[i]));
        chk($sformatf("u%0d.timeout", i),    int'(t), int'(e_to[i]));
    endtask

    // Reports of u0, used by the hand-computed checks.
    int rq_p[$];
    int rq_h[$];
    int rq_l[$];

    // Every-cycle comparison, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (nrst) begin
            chk5(0, int'(p0), int'(h0), v0, l0, t0);
            chk5(1, int'(p2), int'(h2), v2, l2, t2);
            chk5(2, int'(p4), int'(h4), v4, l4, t4);
            if (v0) begin
                rq_p.push_back(int'(p0)); rq_h.push_back(int'(h0)); rq_l.push_back(int'(l0));
            end
        end
    end

    task automatic clr();
        rq_p.delete(); rq_h.delete(); rq_l.delete();
    endtask

    task automatic chk_rep(input int idx, input int p, input int h, input int l);
        if (idx >= rq_p.size()) begin
            chk($sformatf("rep%0d.count", idx), rq_p.size(), idx + 1);
        end else begin
            chk($sformatf("rep%0d.period", idx), rq_p[idx], p);
            chk($sformatf("rep%0d.high", idx),   rq_h[idx], h);
            chk($sformatf("rep%0d.locked", idx), rq_l[idx], l);
        end
    endtask

    task automatic drive_ph(input int p, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                sig_in = (c < hi);
            end
        end
    endtask

    initial begin
        int p, hi;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("rst.period", int'(p0), 0);
        chk("rst.high_time", int'(h0), 0);
        chk("rst.valid_locked_timeout", int'({v0, l0, t0}), 0);

        // 1,1,0,0: first edge arms, second reports 4/2, third locks
        en = 1'b1;
        repeat (2) @(negedge clk);
        clr();
        drive_ph(4, 2, 4);
        chk("div4.count", rq_p.size(), 3);
        chk_rep(0, 4, 2, 0);
        chk_rep(1, 4, 2, 1);

        // divide by 3
        clr();
        drive_ph(3, 1, 5);
        chk_rep(0, 4, 2, 1);
        chk_rep(1, 3, 1, 0);
        chk_rep(2, 3, 1, 1);

        // switch to a 6-cycle input
        clr();
        drive_ph(6, 3, 4);
        chk_rep(0, 3, 1, 1);
        chk_rep(1, 6, 3, 0);
        chk_rep(2, 6, 3, 1);

        // hold high: the 4-bit instance times out, the 8-bit ones do not
        drive_ph(4, 2, 4);
        @(negedge clk); sig_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("u4.timeout_set", int'(t4), 1);
        chk("u4.locked_after_to", int'(l4), 0);
        chk("u4.period_hold", int'(p4), 4);
        chk("u4.high_hold", int'(h4), 2);
        chk("u0.no_timeout", int'(t0), 0);
        drive_ph(4, 2, 3);
        chk("u4.timeout_cleared", int'(t4), 0);

        // constant low long enough for the 8-bit instances to time out
        @(negedge clk); sig_in = 1'b0;
        repeat (300) @(negedge clk);
        chk("u0.timeout_const", int'(t0), 1);
        chk("u2.timeout_const", int'(t2), 1);

        // en dropped mid-period: partial period discarded
        drive_ph(4, 2, 3);
        @(negedge clk); sig_in = 1'b1;
        @(negedge clk); sig_in = 1'b1;
        @(negedge clk); en = 1'b0; sig_in = 1'b0;
        repeat (2) @(negedge clk);
        clr();
        en = 1'b1;
        drive_ph(4, 2, 4);
        chk("reen.count", rq_p.size(), 3);
        chk_rep(0, 4, 2, 1);

        // rise coinciding with en=0 produces no report
        clr();
        @(negedge clk); en = 1'b0; sig_in = 1'b1;
        @(negedge clk); en = 1'b1; sig_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("rise_en0.count", rq_p.size(), 0);

        // randomized periods, duty cycles and enable glitches
        for (int n = 0; n < 60; n++) begin
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(2, 24);
            hi = $urandom_range(1, p - 1);
            drive_ph(p, hi, $urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); en = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                en = 1'b1;
            end
        end

        // asynchronous reset between clock edges
        drive_ph(4, 2, 3);
        @(negedge clk); sig_in = 1'b1;
        #2 nrst = 1'b0;
        #1;
        chk("arst.u0", int'({p0, h0, v0, l0, t0}), 0);
        chk("arst.u2", int'({p2, h2, v2, l2, t2}), 0);
        chk("arst.u4", int'({p4, h4, v4, l4, t4}), 0);
        @(negedge clk); nrst = 1'b1; sig_in = 1'b0;
        @(negedge clk);
        clr();
        drive_ph(4, 2, 4);
        chk_rep(0, 4, 2, 0);
        chk_rep(1, 4, 2, 1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
